// File: rtl/aes_128_pkg.sv
// Shared AES-128 arithmetic for the iterative decryptor: GF(2^8) helpers, S-boxes,
// column mixing, key-schedule steps in both directions, and the FSM state type.
package aes_128_pkg;

   localparam int         NUM_ROUNDS = 10;
   localparam logic [7:0] RCON_FIRST = 8'h01;
   localparam logic [7:0] RCON_LAST  = 8'h36;

   typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ADDK, S_ROUND, S_DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return {1'b0, b[7:1]} ^ (b[0] ? 8'h8d : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x;
      x = gf_inv(b);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one forward step: recover the previous round key from the current one.
   function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = rk[31:0] ^ rk[63:32];
      w2 = rk[63:32] ^ rk[95:64];
      w1 = rk[95:64] ^ rk[127:96];
      w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_128_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last is set.
module aes_128_inv_round
   import aes_128_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [127:0] shifted;
   logic [127:0] subbed;
   logic [127:0] keyed;
   logic [127:0] mixed;

   always_comb begin
      // NOTE: every variable gets a full default before the loops so no path leaves it unassigned (no latch).
      shifted = '0;
      subbed  = '0;
      mixed   = '0;
      // Byte index is 4*col + row; row r rotates right by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127 - 8 * (4 * c + r) -: 8] = state_in[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
         end
      end
      for (int i = 0; i < 16; i++) begin
         subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
      end
      keyed = subbed ^ round_key;
      for (int c = 0; c < 4; c++) begin
         mixed[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
      end
   end

   assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor, one round per clock, forward key in, inverse key schedule on the fly.
// Define AES_DEC_FAULT_EN to add fault_en/fault_bit for single-bit fault injection before the last round.
module aes_128_dec_iter
   import aes_128_pkg::*;
#(
   parameter int KEY_CACHE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ct,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef AES_DEC_FAULT_EN
   input  logic         fault_en,
   input  logic [6:0]   fault_bit,
`endif
   output logic [127:0] pt
);

   state_t       state;
   logic [127:0] st;
   logic [127:0] rk;
   logic [7:0]   rcon;
   logic [3:0]   cnt;
   logic         cache_valid;
   logic [127:0] cache_key;
   logic [127:0] cache_rk;

   logic         accept;
   logic         cache_hit;
   logic         last_round;
   logic [127:0] rk_fwd;
   logic [127:0] rk_inv;
   logic [127:0] fault_mask;
   logic [127:0] round_in;
   logic [127:0] round_out;

   // Combinational out_ready -> in_ready lets a new block load on the edge that retires the old one.
   assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept     = in_valid && in_ready;
   assign cache_hit  = (KEY_CACHE != 0) && cache_valid && (key == cache_key);
   assign last_round = (cnt == 4'd0);
   assign rk_fwd     = fwd_expand(rk, rcon);
   assign rk_inv     = inv_expand(rk, (state == S_ADDK) ? RCON_LAST : rcon);

`ifdef AES_DEC_FAULT_EN
   assign fault_mask = ((state == S_ROUND) && last_round && fault_en) ? (128'd1 << fault_bit) : '0;
`else
   assign fault_mask = '0;
`endif
   assign round_in = st ^ fault_mask;

   aes_128_inv_round u_round (
      .state_in  (round_in),
      .round_key (rk),
      .last      (last_round),
      .state_out (round_out)
   );

   // NOTE: cache_key/cache_rk are plain storage qualified by cache_valid, so only the valid bit needs reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid <= 1'b0;
      end else if (accept && !cache_hit) begin
         cache_key   <= key;
         cache_valid <= 1'b0;
      end else if ((state == S_KEXP) && (cnt == 4'(NUM_ROUNDS - 1))) begin
         cache_rk    <= rk_fwd;
         cache_valid <= 1'b1;
      end
   end

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         st        <= '0;
         rk        <= '0;
         rcon      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         pt        <= '0;
      end else begin
         case (state)
            S_KEXP: begin
               rk   <= rk_fwd;
               rcon <= xtime(rcon);
               cnt  <= cnt + 4'd1;
               if (cnt == 4'(NUM_ROUNDS - 1)) state <= S_ADDK;
            end
            S_ADDK: begin
               st    <= st ^ rk;
               rk    <= rk_inv;
               rcon  <= 8'h1b;
               cnt   <= 4'(NUM_ROUNDS - 1);
               state <= S_ROUND;
            end
            S_ROUND: begin
               st   <= round_out;
               rk   <= rk_inv;
               rcon <= inv_xtime(rcon);
               cnt  <= cnt - 4'd1;
               if (last_round) begin
                  pt        <= round_out;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: ;
         endcase
         // Placed after the case so an accept in DONE overrides the IDLE transition.
         if (accept) begin
            st   <= ct;
            rcon <= RCON_FIRST;
            cnt  <= '0;
            if (cache_hit) begin
               rk    <= cache_rk;
               state <= S_ADDK;
            end else begin
               rk    <= key;
               state <= S_KEXP;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Self-checking bench for aes_128_dec_iter (KEY_CACHE=1): known vectors, handshake corner
// cases, reset abort, cache hits, optional fault injection, and random blocks vs a reference model.
module tb_aes_128_dec_iter;
   import aes_128_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt;
`ifdef AES_DEC_FAULT_EN
   logic         fault_en;
   logic [6:0]   fault_bit;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int bad_ready = 0;
   logic [127:0] rk_at_addk = '0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   logic         cache_ok;
   logic [127:0] cache_k;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      logic [127:0] rk10;
   } vec_t;
   vec_t vecs [2];

   aes_128_dec_iter #(.KEY_CACHE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef AES_DEC_FAULT_EN
      .fault_en  (fault_en),
      .fault_bit (fault_bit),
`endif
      .pt        (pt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dut.state == S_ADDK) rk_at_addk <= dut.rk;
      if (in_ready && (dut.state == S_KEXP || dut.state == S_ADDK || dut.state == S_ROUND))
         bad_ready <= bad_ready + 1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // FIPS-197 reference: full forward key expansion into w[0..43], then the textbook inverse cipher on a byte array.
   function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c, output logic [127:0] rk10);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   tmp [16];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] rkey;
      logic [127:0] res;
      logic [7:0]   a0, a1, a2, a3;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i - 4] ^ t;
      end
      rk10 = {w[40], w[41], w[42], w[43]};
      for (int i = 0; i < 16; i++) s[i] = c[127 - 8 * i -: 8] ^ rk10[127 - 8 * i -: 8];
      for (int r = 9; r >= 0; r--) begin
         for (int cc = 0; cc < 4; cc++)
            for (int rr = 0; rr < 4; rr++)
               tmp[4 * cc + rr] = isb[s[4 * ((cc + 4 - rr) % 4) + rr]];
         rkey = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
         for (int i = 0; i < 16; i++) s[i] = tmp[i] ^ rkey[127 - 8 * i -: 8];
         if (r > 0) begin
            for (int cc = 0; cc < 4; cc++) begin
               a0 = s[4 * cc]; a1 = s[4 * cc + 1]; a2 = s[4 * cc + 2]; a3 = s[4 * cc + 3];
               s[4 * cc]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
               s[4 * cc + 1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
               s[4 * cc + 2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
               s[4 * cc + 3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
      return res;
   endfunction

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   // Caller is #1 after a posedge. Accepts one block, waits for out_valid, holds out_ready low for stall cycles.
   task automatic run_block(input logic [127:0] k, input logic [127:0] c, input int stall,
                            output logic [127:0] p, output int lat);
      int guard;
      key = k;
      ct = c;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) check("accept timeout", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      p = pt;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall pt stable", pt, p);
         check("stall out_valid held", 128'(out_valid), 128'd1);
         check("stall in_ready low", 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("retire out_valid low", 128'(out_valid), 128'd0);
   endtask

   task automatic do_block(input string name, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] exp_pt, input logic [127:0] exp_rk10, input int stall);
      logic [127:0] got;
      int lat;
      int exp_lat;
      exp_lat = (cache_ok && k == cache_k) ? 11 : 21;
      run_block(k, c, stall, got, lat);
      check({name, " pt"}, got, exp_pt);
      check({name, " latency"}, 128'(lat), 128'(exp_lat));
      check({name, " rk10"}, rk_at_addk, exp_rk10);
      cache_ok = 1'b1;
      cache_k = k;
   endtask

   initial begin
      logic [127:0] m_pt, m_rk, got, k, c;
      int lat, high_cnt, nb;

      build_sbox();
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; ct = '0;
`ifdef AES_DEC_FAULT_EN
      fault_en = 1'b0; fault_bit = '0;
`endif
      cache_ok = 1'b0; cache_k = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 128'(out_valid), 128'd0);
      check("reset pt", pt, 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready after reset", 128'(in_ready), 128'd1);

      // Known-answer vectors, including the round-10 key reached by the forward expansion.
      for (int i = 0; i < 2; i++) do_block($sformatf("kat%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].rk10, 0);

      // Back-to-back: in_valid held, out_ready high; second block loads on the DONE edge.
      key = vecs[0].key; ct = vecs[0].ct; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      key = vecs[1].key; ct = vecs[1].ct;
      lat = 0;
      while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
      check("b2b first pt", pt, vecs[0].pt);
      check("b2b first latency", 128'(lat), 128'd21);
      check("b2b in_ready in DONE", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b retire", 128'(out_valid), 128'd0);
      check("b2b second accepted", 128'(in_ready), 128'd0);
      lat = 0;
      while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
      check("b2b second pt", pt, vecs[1].pt);
      check("b2b second latency", 128'(lat), 128'd21);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("b2b final retire", 128'(out_valid), 128'd0);
      cache_ok = 1'b1; cache_k = vecs[1].key;

      // Downstream stall of 5 cycles in DONE.
      do_block("stall", vecs[0].key, vecs[0].ct, vecs[0].pt, vecs[0].rk10, 5);
      repeat (3) begin
         @(posedge clk); #1;
         check("single transfer", 128'(out_valid), 128'd0);
      end

      // Reset 12 cycles into a block aborts it and clears the key cache.
      key = vecs[0].key; ct = vecs[0].ct; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort out_valid", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
      check("abort in_ready", 128'(in_ready), 128'd1);
      high_cnt = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) high_cnt++;
      end
      check("abort no output", 128'(high_cnt), 128'd0);
      cache_ok = 1'b0;
      do_block("rerun", vecs[0].key, vecs[0].ct, vecs[0].pt, vecs[0].rk10, 0);

      // Key cache: first use of key 2 misses, repeat hits.
      do_block("cache miss", vecs[1].key, vecs[1].ct, vecs[1].pt, vecs[1].rk10, 0);
      do_block("cache hit", vecs[1].key, vecs[1].ct, vecs[1].pt, vecs[1].rk10, 0);

`ifdef AES_DEC_FAULT_EN
      fault_en = 1'b1; fault_bit = 7'd0;
      run_block(vecs[1].key, vecs[1].ct, 0, got, lat);
      fault_en = 1'b0;
      nb = 0;
      for (int i = 0; i < 16; i++) if ((got[127 - 8 * i -: 8] ^ vecs[1].pt[127 - 8 * i -: 8]) != 8'h00) nb++;
      check("fault one byte", 128'(nb), 128'd1);
`endif

      // Random blocks against the model, with occasional key reuse and random stalls.
      for (int i = 0; i < 24; i++) begin
         if (cache_ok && $urandom_range(0, 2) == 0) k = cache_k;
         else k = {$urandom, $urandom, $urandom, $urandom};
         c = {$urandom, $urandom, $urandom, $urandom};
         m_pt = model_dec(k, c, m_rk);
         do_block($sformatf("rand%0d", i), k, c, m_pt, m_rk, $urandom_range(0, 3));
      end

      check("in_ready never high while busy", 128'(bad_ready), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
